// File: rtl/dpu_op_arbiter.sv
// Round-robin arbiter sharing one DPU micro-op port between two sequencers, with lock/watchdog.
// Optional per-requester accept counters are built only when DPU_ARB_STATS_EN is defined.
module dpu_op_arbiter #(
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic        req0_lock,
    input  logic        req1_lock,
    input  logic [24:0] req0_op,
    input  logic [24:0] req1_op,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [3:0]  rsp_cc,
    output logic [3:0]  dpu_n,
    output logic [3:0]  dpu_a,
    output logic [3:0]  dpu_b,
    output logic [3:0]  dpu_r,
    output logic [7:0]  dpu_mdata,
    output logic        dpu_oe,
    output logic        dpu_valid,
    input  logic [3:0]  dpu_cc,
    output logic        owner,
    output logic        lock_err,
    output logic [15:0] gnt_cnt0,
    output logic [15:0] gnt_cnt1
);

    typedef enum logic [1:0] {StOpen, StLock0, StLock1} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [7:0]  wd_q, wd_d;
    logic        lock_err_q, lock_err_d;

    logic [24:1] dpu_fields_q;
    logic        dpu_oe_q, dpu_valid_q, tag_q;
    logic        rsp_valid_q, rsp_tag_q;
    logic [3:0]  rsp_cc_q;

    logic        accept, gnt_idx, acc_lock;
    logic [24:0] acc_op;

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            StLock0: req0_ready = req0_valid;
            StLock1: req1_ready = req1_valid;
            default: begin
                // On a tie the requester that was not granted last wins.
                if (req0_valid && req1_valid) begin
                    req0_ready = owner_q;
                    req1_ready = !owner_q;
                end else begin
                    req0_ready = req0_valid;
                    req1_ready = req1_valid;
                end
            end
        endcase
    end

    assign accept   = req0_ready | req1_ready;
    assign gnt_idx  = req1_ready;
    assign acc_lock = gnt_idx ? req1_lock : req0_lock;
    assign acc_op   = gnt_idx ? req1_op : req0_op;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wd_d       = wd_q;
        lock_err_d = 1'b0;
        if (accept) begin
            owner_d = gnt_idx;
            wd_d    = 8'd0;
            if (acc_lock) begin
                state_d = gnt_idx ? StLock1 : StLock0;
            end else begin
                state_d = StOpen;
            end
        end else if (state_q != StOpen) begin
            // A lock with no accept means the owner is idle this cycle.
            if (wd_q == 8'(LOCK_TIMEOUT - 1)) begin
                state_d    = StOpen;
                wd_d       = 8'd0;
                lock_err_d = 1'b1;
            end else begin
                wd_d = wd_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StOpen;
            owner_q    <= 1'b1;
            wd_q       <= 8'd0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wd_q       <= wd_d;
            lock_err_q <= lock_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dpu_fields_q <= '0;
            dpu_oe_q     <= 1'b0;
            dpu_valid_q  <= 1'b0;
            tag_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_tag_q    <= 1'b0;
            rsp_cc_q     <= 4'd0;
        end else begin
            dpu_valid_q <= accept;
            if (accept) begin
                dpu_fields_q <= acc_op[24:1];
                dpu_oe_q     <= acc_op[0];
                tag_q        <= gnt_idx;
            end else begin
                dpu_oe_q <= 1'b0;
            end
            rsp_valid_q <= dpu_valid_q;
            rsp_tag_q   <= tag_q;
            if (dpu_valid_q) begin
                rsp_cc_q <= dpu_cc;
            end
        end
    end

`ifdef DPU_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            if (req0_ready) cnt0_q <= cnt0_q + 16'd1;
            if (req1_ready) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`else
    assign gnt_cnt0 = 16'h0000;
    assign gnt_cnt1 = 16'h0000;
`endif

    assign {dpu_n, dpu_a, dpu_b, dpu_r, dpu_mdata} = dpu_fields_q;
    assign dpu_oe     = dpu_oe_q;
    assign dpu_valid  = dpu_valid_q;
    assign rsp0_valid = rsp_valid_q & !rsp_tag_q;
    assign rsp1_valid = rsp_valid_q & rsp_tag_q;
    assign rsp_cc     = rsp_cc_q;
    assign owner      = owner_q;
    assign lock_err   = lock_err_q;

endmodule

// File: tb/tb_dpu_op_arbiter.sv
// Self-checking bench for dpu_op_arbiter: vector table, corner sequences and a random run
// checked against a cycle-history reference model.
module tb_dpu_op_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req1_valid, req0_lock, req1_lock;
    logic [24:0] req0_op, req1_op;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [3:0]  rsp_cc, dpu_n, dpu_a, dpu_b, dpu_r, dpu_cc;
    logic [7:0]  dpu_mdata;
    logic        dpu_oe, dpu_valid, owner, lock_err;
    logic [15:0] gnt_cnt0, gnt_cnt1;

    always #5 clk = ~clk;

    function automatic logic [3:0] cc_of(input logic [3:0] r, input logic [3:0] a);
        return (r == 4'd14) ? 4'b1000 : (r ^ a);
    endfunction

    // DPU stand-in: condition codes derived from the op it is shown.
    assign dpu_cc = dpu_valid ? cc_of(dpu_r, dpu_a) : 4'hA;

    dpu_op_arbiter #(.LOCK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_lock(req0_lock), .req1_lock(req1_lock),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_cc(rsp_cc),
        .dpu_n(dpu_n), .dpu_a(dpu_a), .dpu_b(dpu_b), .dpu_r(dpu_r),
        .dpu_mdata(dpu_mdata), .dpu_oe(dpu_oe), .dpu_valid(dpu_valid), .dpu_cc(dpu_cc),
        .owner(owner), .lock_err(lock_err), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: lock holder (-1 = none), last grant, idle count, and a
    // two-deep history of what was accepted in the previous cycles.
    int          m_lock;
    logic        m_owner;
    int          m_idle;
    logic        m_err;
    logic [3:0]  m_rsp_cc;
    logic [15:0] m_cnt0, m_cnt1;
    logic [24:0] last_op;
    logic        h1_acc, h1_who, h2_acc, h2_who;
    logic [24:0] h1_op, h2_op;

    task automatic model_reset();
        m_lock = -1; m_owner = 1'b1; m_idle = 0; m_err = 1'b0; m_rsp_cc = 4'd0;
        m_cnt0 = 16'd0; m_cnt1 = 16'd0; last_op = '0;
        h1_acc = 1'b0; h1_who = 1'b0; h1_op = '0;
        h2_acc = 1'b0; h2_who = 1'b0; h2_op = '0;
    endtask

    task automatic apply(input logic a0, input logic a1, input logic k0, input logic k1);
        req0_valid = a0; req1_valid = a1; req0_lock = k0; req1_lock = k1;
        req0_op = 25'($urandom); req1_op = 25'($urandom);
        #2;
    endtask

    task automatic tick();
        logic e0, e1, who, lk;
        logic [24:0] op;
        if (m_lock == 0) begin
            e0 = req0_valid; e1 = 1'b0;
        end else if (m_lock == 1) begin
            e0 = 1'b0; e1 = req1_valid;
        end else if (req0_valid && req1_valid) begin
            e0 = m_owner; e1 = !m_owner;
        end else begin
            e0 = req0_valid; e1 = req1_valid;
        end
        chk("ready0", 32'(req0_ready), 32'(e0));
        chk("ready1", 32'(req1_ready), 32'(e1));
        chk("dpu_valid", 32'(dpu_valid), 32'(h1_acc));
        chk("dpu_oe", 32'(dpu_oe), 32'(h1_acc & h1_op[0]));
        chk("dpu_fields", 32'({dpu_n, dpu_a, dpu_b, dpu_r, dpu_mdata}), 32'(last_op[24:1]));
        if (h2_acc) m_rsp_cc = cc_of(h2_op[12:9], h2_op[20:17]);
        chk("rsp0_valid", 32'(rsp0_valid), 32'(h2_acc & !h2_who));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(h2_acc & h2_who));
        chk("rsp_cc", 32'(rsp_cc), 32'(m_rsp_cc));
        chk("lock_err", 32'(lock_err), 32'(m_err));
        chk("owner", 32'(owner), 32'(m_owner));
`ifdef DPU_ARB_STATS_EN
        chk("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt0));
        chk("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt1));
`else
        chk("gnt_cnt0", 32'(gnt_cnt0), 32'd0);
        chk("gnt_cnt1", 32'(gnt_cnt1), 32'd0);
`endif
        who = e1;
        lk  = who ? req1_lock : req0_lock;
        op  = who ? req1_op : req0_op;
        m_err = 1'b0;
        if (e0 || e1) begin
            m_owner = who;
            m_lock  = lk ? int'(who) : -1;
            m_idle  = 0;
            last_op = op;
            if (who) m_cnt1 = m_cnt1 + 16'd1; else m_cnt0 = m_cnt0 + 16'd1;
        end else if (m_lock >= 0) begin
            m_idle++;
            if (m_idle == int'(TO)) begin
                m_lock = -1; m_idle = 0; m_err = 1'b1;
            end
        end
        h2_acc = h1_acc; h2_who = h1_who; h2_op = h1_op;
        h1_acc = e0 | e1; h1_who = who; h1_op = op;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic v0, v1, l0, l1;
        logic e0, e1;
    } vec_t;

    vec_t vecs[11];
    logic [15:0] exp_cnt1;

    initial begin
        // Fairness: 0,1,0,1,0,1; then req0 holds the lock for 3 ops; req1 on the 4th.
        vecs[0]  = '{1, 1, 0, 0, 1, 0};
        vecs[1]  = '{1, 1, 0, 0, 0, 1};
        vecs[2]  = '{1, 1, 0, 0, 1, 0};
        vecs[3]  = '{1, 1, 0, 0, 0, 1};
        vecs[4]  = '{1, 1, 0, 0, 1, 0};
        vecs[5]  = '{1, 1, 0, 0, 0, 1};
        vecs[6]  = '{1, 1, 1, 0, 1, 0};
        vecs[7]  = '{1, 1, 1, 0, 1, 0};
        vecs[8]  = '{1, 1, 0, 0, 1, 0};
        vecs[9]  = '{1, 1, 0, 0, 0, 1};
        vecs[10] = '{0, 0, 0, 0, 0, 0};

        req0_valid = 0; req1_valid = 0; req0_lock = 0; req1_lock = 0;
        req0_op = '0; req1_op = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply(0, 0, 0, 0);
        tick();

        foreach (vecs[i]) begin
            apply(vecs[i].v0, vecs[i].v1, vecs[i].l0, vecs[i].l1);
            chk($sformatf("vec%0d_ready0", i), 32'(req0_ready), 32'(vecs[i].e0));
            chk($sformatf("vec%0d_ready1", i), 32'(req1_ready), 32'(vecs[i].e1));
            tick();
        end

        // Watchdog: lock taken, owner idle for TO cycles, lock broken.
        apply(1, 0, 1, 0);
        tick();
        for (int i = 0; i < int'(TO); i++) begin
            apply(0, 1, 0, 0);
            chk("wd_block", 32'(req1_ready), 32'd0);
            tick();
        end
        apply(0, 1, 0, 0);
        chk("wd_err", 32'(lock_err), 32'd1);
        chk("wd_release", 32'(req1_ready), 32'd1);
        tick();
        apply(0, 0, 0, 0);
        chk("wd_err_pulse", 32'(lock_err), 32'd0);
        tick();

        // Owner returns exactly on the cycle the watchdog would fire.
        apply(1, 0, 1, 0);
        tick();
        for (int i = 0; i < int'(TO) - 1; i++) begin
            apply(0, 1, 0, 0);
            tick();
        end
        apply(1, 1, 0, 0);
        chk("coll_ready0", 32'(req0_ready), 32'd1);
        chk("coll_ready1", 32'(req1_ready), 32'd0);
        tick();
        apply(0, 0, 0, 0);
        chk("coll_no_err", 32'(lock_err), 32'd0);
        tick();

        // Condition-code return for a req1 op with r=14.
        apply(0, 1, 0, 0);
        req1_op[12:9] = 4'd14;
        exp_cnt1 = m_cnt1 + 16'd1;
        tick();
        apply(0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0);
        chk("cc_rsp1", 32'(rsp1_valid), 32'd1);
        chk("cc_value", 32'(rsp_cc), 32'h8);
`ifdef DPU_ARB_STATS_EN
        chk("cc_cnt1", 32'(gnt_cnt1), 32'(exp_cnt1));
`endif
        tick();

        for (int c = 0; c < 400; c++) begin
            apply($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
            tick();
        end

        // Reset while an op is in flight: nothing may emerge afterwards.
        apply(1, 1, 1, 0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_dpu_valid", 32'(dpu_valid), 32'd0);
        chk("rst_dpu_fields", 32'({dpu_n, dpu_a, dpu_b, dpu_r, dpu_mdata, dpu_oe}), 32'd0);
        chk("rst_rsp", 32'({rsp0_valid, rsp1_valid, rsp_cc}), 32'd0);
        chk("rst_owner", 32'(owner), 32'd1);
        chk("rst_lock_err", 32'(lock_err), 32'd0);
        chk("rst_cnt", 32'({gnt_cnt0, gnt_cnt1}), 32'd0);
        req0_valid = 0; req1_valid = 0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0);
            tick();
        end
        apply(1, 1, 0, 0);
        chk("post_rst_tie", 32'(req0_ready), 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
